mem_responder: RTL and testbench

//   Memory-side responder for the multicycle core: serves instruction fetches, loads and stores

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and lane helpers for the mem_responder RAM slice.
package mem_pkg;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    function automatic size_e to_size(input logic [1:0] s);
        return s == 2'b00 ? SZ_B : s == 2'b01 ? SZ_H : SZ_W;
    endfunction

    function automatic logic [3:0] lane_strobe(input size_e sz, input logic [1:0] a);
        return sz == SZ_B ? 4'b0001 << a : sz == SZ_H ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] a);
        return (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
    endfunction

    function automatic logic [1:0] align_low(input size_e sz, input logic [1:0] a);
        return sz == SZ_B ? a : sz == SZ_H ? {a[1], 1'b0} : 2'b00;
    endfunction

    function automatic logic [31:0] wdata_lanes(input size_e sz, input logic [31:0] d);
        return sz == SZ_B ? {4{d[7:0]}} : sz == SZ_H ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e sz,
                                                input logic [1:0] a, input logic uns);
        logic [31:0] sh;
        sh = word >> {a, 3'b000};
        return sz == SZ_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
               sz == SZ_H ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
    endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32 single-port RAM with byte write enables and registered read.
module mem_array #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: latency-programmable RAM responder with RV32 byte/half/word sizing.
// MEM_MISALIGN_CHECK_EN: flag misaligned accesses with rsp_err instead of aligning them down.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam logic [3:0] CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d, uns_q, uns_d, err_q, err_d;
    size_e         size_q, size_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    size_e         size_in, size_c;
    logic [AW+1:0] addr_in, addr_c;
    logic          err_in, err_c, we_c, idle, accept, commit;
    logic [31:0]   wdata_c, mem_rdata;
    logic [3:0]    mem_be;
    logic          unused_hi;

    assign unused_hi = ^req_addr[31:AW+2];

    always_comb begin
        size_in = to_size(req_size);
`ifdef MEM_MISALIGN_CHECK_EN
        err_in  = misaligned(size_in, req_addr[1:0]);
        addr_in = req_addr[AW+1:0];
`else
        err_in  = 1'b0;
        addr_in = {req_addr[AW+1:2], align_low(size_in, req_addr[1:0])};
`endif
    end

    assign idle      = state_q == S_IDLE;
    assign req_ready = idle;
    assign accept    = req_valid && idle;

    // With LATENCY=1 the RAM access happens on the accept edge, so use the live request.
    assign we_c    = idle ? req_we    : we_q;
    assign size_c  = idle ? size_in   : size_q;
    assign addr_c  = idle ? addr_in   : addr_q;
    assign err_c   = idle ? err_in    : err_q;
    assign wdata_c = idle ? req_wdata : wdata_q;
    assign commit  = LATENCY == 1 ? accept : (state_q == S_WAIT && cnt_q == 4'd0);
    assign mem_be  = (commit && we_c && !err_c) ? lane_strobe(size_c, addr_c[1:0]) : 4'b0000;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = LATENCY == 1 ? S_RESP : S_WAIT;
                cnt_d   = CNT_INIT;
                we_d    = req_we;
                uns_d   = req_unsigned;
                err_d   = err_in;
                size_d  = size_in;
                addr_d  = addr_in;
                wdata_d = req_wdata;
            end
            S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
                    else cnt_d = cnt_q - 4'd1;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_W;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .en    (commit),
        .we    (mem_be),
        .addr  (addr_c[AW+1:2]),
        .wdata (wdata_lanes(size_c, wdata_c)),
        .rdata (mem_rdata)
    );

    // The RAM read register only moves on commit, so the response stays stable while stalled.
    assign rsp_valid = state_q == S_RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ?
                       load_extend(mem_rdata, size_q, addr_q[1:0], uns_q) : 32'd0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench with a byte-array reference memory.
module tb_mem_responder;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0, cyc = 0;
    bit          bp_force = 1'b0;
    logic [7:0]  mdl [4*DEPTH];
    logic [32:0] exp_q [$];
    int          acc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: byte-addressed memory, wrap at 4*DEPTH bytes.
    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int n, a;
        logic [31:0] v;
        n  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        a  = int'(addr % 32'(4*DEPTH));
        rd = '0;
        er = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (a % n != 0) begin
            er = 1'b1;
            return;
        end
`else
        a -= a % n;
`endif
        if (we) begin
            for (int i = 0; i < n; i++) mdl[a+i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a+i];
            if (!uns && n < 4 && v[8*n-1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd);
        logic [31:0] r;
        logic        e;
        int          n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        model(we, addr, sz, uns, wd, r, e);
        exp_q.push_back({e, r});
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now("accept_timeout");
        else acc_q.push_back(cyc);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    initial forever begin
        @(posedge clk); #1;
        rsp_ready = bp_force ? 1'b0 : ($urandom_range(3) != 0);
    end

    // Monitor: latency, stability under backpressure, and scoreboard compare on handshake.
    logic        pv = 1'b0, phs = 1'b0, perr = 1'b0;
    logic [31:0] prd = '0;
    logic [32:0] e;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv  = 1'b0;
            phs = 1'b0;
        end else begin
            if (rsp_valid) chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (rsp_valid && pv && !phs) begin
                chk("rdata_stable", rsp_rdata, prd);
                chk("err_stable", 32'(rsp_err), 32'(perr));
            end else if (rsp_valid) begin
                if (acc_q.size() == 0) fail_now("unexpected_rsp");
                else chk("latency", 32'(cyc - acc_q.pop_front()), 32'(LATENCY));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) fail_now("rsp_without_request");
                else begin
                    e = exp_q.pop_front();
                    chk("rdata", rsp_rdata, e[31:0]);
                    chk("err", 32'(rsp_err), 32'(e[32]));
                end
            end
            pv   = rsp_valid;
            prd  = rsp_rdata;
            perr = rsp_err;
            phs  = rsp_valid && rsp_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) issue(1'b1, 32'(4*i), 2'd2, 1'b0, $urandom);

        issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        issue(1'b1, 32'h11, 2'd0, 1'b0, 32'h7F);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        issue(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
        issue(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
        issue(1'b1, 32'h12, 2'd1, 1'b0, 32'h8001);
        issue(1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
        issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        wait_drain();

        bp_force = 1'b1;
        @(posedge clk);
        fork
            begin
                issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
                issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0);
            end
            begin
                n = 0;
                while (!rsp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (!rsp_valid) fail_now("bp_rsp_timeout");
                repeat (5) @(negedge clk);
                bp_force = 1'b0;
            end
        join
        wait_drain();

        issue(1'b1, 32'h16, 2'd2, 1'b0, 32'h12345678);
        issue(1'b0, 32'h14, 2'd2, 1'b0, 32'h0);
        issue(1'b0, 32'h16, 2'd2, 1'b0, 32'h0);
        issue(1'b0, 32'h15, 2'd1, 1'b1, 32'h0);
        issue(1'b1, 32'h1003, 2'd3, 1'b0, 32'hCAFEF00D);
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);

        for (int i = 0; i < 150; i++) begin
            a = 32'($urandom_range(255));
            if ($urandom_range(3) == 0) a |= $urandom & 32'hFFFF_F000;
            issue(1'($urandom_range(1)), a, 2'($urandom_range(3)), 1'($urandom_range(1)), $urandom);
        end
        wait_drain();

        // Reset during WAIT of a store: the store must be dropped.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_wdata = 32'hAAAAAAAA;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
